// File: rtl/complex_mac_pkg.sv
// Shared definitions for the sequential complex multiply-accumulate.
//   state_e     : FSM states (IDLE, MUL, ACC, RES)
//   P_AC..P_BC  : step index of each partial product; the MUL step counter
//                 value selects which partial product the shared multiplier
//                 computes in that cycle
//   res_width() : accumulator / result width for a given operand width and
//                 number of guard bits
package complex_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    RES  = 2'd3
  } state_e;

  localparam logic [1:0] P_AC = 2'd0;
  localparam logic [1:0] P_BD = 2'd1;
  localparam logic [1:0] P_AD = 2'd2;
  localparam logic [1:0] P_BC = 2'd3;

  // Full product (2*dw) plus one bit for the sum/difference of two products,
  // plus guard bits so that 2^acc_guard worst-case products cannot overflow.
  function automatic int res_width(input int data_width, input int acc_guard);
    return data_width + data_width + 32'sd1 + acc_guard;
  endfunction

endpackage

// File: rtl/complex_mac_sat_add.sv
// Signed WIDTH-bit adder used for one accumulator component.
// Optional feature macro: COMPLEX_MAC_SAT_EN
//   defined   : result clamps to the signed WIDTH-bit range, ovf flags a clamp
//   undefined : two's-complement wrap, ovf is constant 0
// Ports:
//   in_a, in_b : signed addends
//   sum        : signed result
//   ovf        : 1 when the true sum did not fit and was clamped
module complex_mac_sat_add #(
  parameter int WIDTH = 32'd21
) (
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);

`ifdef COMPLEX_MAC_SAT_EN
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] wide_s;

  // One extra bit of headroom: the two top bits disagree exactly on overflow,
  // and the top bit then gives the direction of the clamp.
  always_comb begin
    wide_s = {in_a[WIDTH-1], in_a} + {in_b[WIDTH-1], in_b};
    if (wide_s[WIDTH] != wide_s[WIDTH-1]) begin
      ovf = 1'b1;
      if (wide_s[WIDTH]) begin
        sum = MIN_V;
      end else begin
        sum = MAX_V;
      end
    end else begin
      ovf = 1'b0;
      sum = wide_s[WIDTH-1:0];
    end
  end
`else
  // Plain wrapping add.
  always_comb begin
    sum = in_a + in_b;
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/complex_mac_seq.sv
// Sequential signed complex multiply-accumulate with one shared multiplier.
// Each accepted operand set (a+bj, c+dj) takes four MUL cycles (ac, bd, ad,
// bc) and one ACC cycle; the product (optionally by conj(op_2)) is added to
// the accumulator. When the operand set was marked op_last the block holds
// the accumulated result in RES until the consumer takes it.
// Optional feature macro: COMPLEX_MAC_SAT_EN (saturating accumulate + res_ovf).
// Ports:
//   clk, sw_rst          : clock, synchronous active-high reset
//   op_val / op_ready    : operand handshake (op_ready only in IDLE)
//   op_1_re/im, op_2_re/im, op_conj, op_last : operand set
//   res_val / res_ready  : result handshake (res_val only in RES)
//   res_re, res_im       : registered accumulator contents
//   res_ovf              : sticky saturation flag (0 when macro undefined)
module complex_mac_seq
  import complex_mac_pkg::*;
#(
  parameter  int DATA_WIDTH = 32'd8,
  parameter  int ACC_GUARD  = 32'd4,
  localparam int RES_WIDTH  = res_width(DATA_WIDTH, ACC_GUARD)
) (
  input  logic                         clk,
  input  logic                         sw_rst,
  input  logic                         op_val,
  output logic                         op_ready,
  input  logic signed [DATA_WIDTH-1:0] op_1_re,
  input  logic signed [DATA_WIDTH-1:0] op_1_im,
  input  logic signed [DATA_WIDTH-1:0] op_2_re,
  input  logic signed [DATA_WIDTH-1:0] op_2_im,
  input  logic                         op_conj,
  input  logic                         op_last,
  output logic                         res_val,
  input  logic                         res_ready,
  output logic signed [RES_WIDTH-1:0]  res_re,
  output logic signed [RES_WIDTH-1:0]  res_im,
  output logic                         res_ovf
);

  localparam int PROD_W = DATA_WIDTH + DATA_WIDTH;
  localparam int P_W    = PROD_W + 32'sd1;

  state_e                         state_q, state_d;
  logic [1:0]                     cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic                           conj_q, conj_d, last_q, last_d;
  logic signed [PROD_W-1:0]       ac_q, ac_d, bd_q, bd_d, ad_q, ad_d, bc_q, bc_d;
  logic signed [RES_WIDTH-1:0]    acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                           ovf_q, ovf_d;
  logic                           res_val_q, res_val_d;

  logic signed [DATA_WIDTH-1:0]   mul_x_s, mul_y_s;
  logic signed [PROD_W-1:0]       mul_p_s;
  logic signed [P_W-1:0]          ac_x_s, bd_x_s, ad_x_s, bc_x_s;
  logic signed [P_W-1:0]          p_re_s, p_im_s;
  logic signed [RES_WIDTH-1:0]    p_re_ext_s, p_im_ext_s;
  logic signed [RES_WIDTH-1:0]    sum_re_s, sum_im_s;
  logic                           ovf_re_s, ovf_im_s;

  // Shared multiplier: the step counter picks which operand pair it sees.
  always_comb begin
    mul_x_s = a_q;
    mul_y_s = c_q;
    case (cnt_q)
      P_AC: begin mul_x_s = a_q; mul_y_s = c_q; end
      P_BD: begin mul_x_s = b_q; mul_y_s = d_q; end
      P_AD: begin mul_x_s = a_q; mul_y_s = d_q; end
      P_BC: begin mul_x_s = b_q; mul_y_s = c_q; end
      default: begin mul_x_s = a_q; mul_y_s = c_q; end
    endcase
    mul_p_s = mul_x_s * mul_y_s;
  end

  // Combine partial products into the complex product and sign-extend it.
  always_comb begin
    ac_x_s = {ac_q[PROD_W-1], ac_q};
    bd_x_s = {bd_q[PROD_W-1], bd_q};
    ad_x_s = {ad_q[PROD_W-1], ad_q};
    bc_x_s = {bc_q[PROD_W-1], bc_q};
    if (conj_q) begin
      p_re_s = ac_x_s + bd_x_s;
      p_im_s = bc_x_s - ad_x_s;
    end else begin
      p_re_s = ac_x_s - bd_x_s;
      p_im_s = bc_x_s + ad_x_s;
    end
    p_re_ext_s = {{(RES_WIDTH-P_W){p_re_s[P_W-1]}}, p_re_s};
    p_im_ext_s = {{(RES_WIDTH-P_W){p_im_s[P_W-1]}}, p_im_s};
  end

  complex_mac_sat_add #(.WIDTH(RES_WIDTH)) u_add_re (
    .in_a (acc_re_q),
    .in_b (p_re_ext_s),
    .sum  (sum_re_s),
    .ovf  (ovf_re_s)
  );

  complex_mac_sat_add #(.WIDTH(RES_WIDTH)) u_add_im (
    .in_a (acc_im_q),
    .in_b (p_im_ext_s),
    .sum  (sum_im_s),
    .ovf  (ovf_im_s)
  );

  // Reset must close the operand handshake even in the same cycle.
  assign op_ready = (state_q == IDLE) && !sw_rst;

  // FSM next state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    conj_d    = conj_q;
    last_d    = last_q;
    ac_d      = ac_q;
    bd_d      = bd_q;
    ad_d      = ad_q;
    bc_d      = bc_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    ovf_d     = ovf_q;
    res_val_d = res_val_q;
    case (state_q)
      IDLE: begin
        if (op_val) begin
          a_d     = op_1_re;
          b_d     = op_1_im;
          c_d     = op_2_re;
          d_d     = op_2_im;
          conj_d  = op_conj;
          last_d  = op_last;
          cnt_d   = 2'd0;
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        case (cnt_q)
          P_AC:    ac_d = mul_p_s;
          P_BD:    bd_d = mul_p_s;
          P_AD:    ad_d = mul_p_s;
          P_BC:    bc_d = mul_p_s;
          default: ac_d = ac_q;
        endcase
        if (cnt_q == P_BC) begin
          state_d = ACC;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ACC: begin
        acc_re_d = sum_re_s;
        acc_im_d = sum_im_s;
        ovf_d    = ovf_q | ovf_re_s | ovf_im_s;
        if (last_q) begin
          state_d   = RES;
          res_val_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RES: begin
        if (res_ready) begin
          acc_re_d  = {RES_WIDTH{1'b0}};
          acc_im_d  = {RES_WIDTH{1'b0}};
          ovf_d     = 1'b0;
          res_val_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = RES;
        end
      end
      default: begin
        state_d   = IDLE;
        res_val_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      a_q       <= {DATA_WIDTH{1'b0}};
      b_q       <= {DATA_WIDTH{1'b0}};
      c_q       <= {DATA_WIDTH{1'b0}};
      d_q       <= {DATA_WIDTH{1'b0}};
      conj_q    <= 1'b0;
      last_q    <= 1'b0;
      ac_q      <= {PROD_W{1'b0}};
      bd_q      <= {PROD_W{1'b0}};
      ad_q      <= {PROD_W{1'b0}};
      bc_q      <= {PROD_W{1'b0}};
      acc_re_q  <= {RES_WIDTH{1'b0}};
      acc_im_q  <= {RES_WIDTH{1'b0}};
      ovf_q     <= 1'b0;
      res_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      conj_q    <= conj_d;
      last_q    <= last_d;
      ac_q      <= ac_d;
      bd_q      <= bd_d;
      ad_q      <= ad_d;
      bc_q      <= bc_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      ovf_q     <= ovf_d;
      res_val_q <= res_val_d;
    end
  end

  assign res_val = res_val_q;
  assign res_re  = acc_re_q;
  assign res_im  = acc_im_q;
  assign res_ovf = ovf_q;

endmodule

// File: tb/tb_complex_mac_seq.sv
module tb_complex_mac_seq;

  localparam int RW = 21;
  localparam longint RMAX = (64'sd1 <<< (RW - 1)) - 64'sd1;
  localparam longint RMIN = -(64'sd1 <<< (RW - 1));
  localparam longint MODV = 64'sd1 <<< RW;
`ifdef COMPLEX_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sw_rst, op_val, op_ready, op_conj, op_last;
  logic res_val, res_ready, res_ovf;
  logic signed [7:0] op_1_re, op_1_im, op_2_re, op_2_im;
  logic signed [RW-1:0] res_re, res_im;

  complex_mac_seq dut (
    .clk(clk), .sw_rst(sw_rst), .op_val(op_val), .op_ready(op_ready),
    .op_1_re(op_1_re), .op_1_im(op_1_im), .op_2_re(op_2_re), .op_2_im(op_2_im),
    .op_conj(op_conj), .op_last(op_last), .res_val(res_val),
    .res_ready(res_ready), .res_re(res_re), .res_im(res_im), .res_ovf(res_ovf)
  );

  int checks = 0;
  int errors = 0;

  // reference accumulator (plain integers)
  longint m_re, m_im;
  bit     m_ovf;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint fit(input longint x, output bit clamped);
    longint y;
    clamped = 1'b0;
    if (SAT) begin
      if (x > RMAX) begin clamped = 1'b1; return RMAX; end
      if (x < RMIN) begin clamped = 1'b1; return RMIN; end
      return x;
    end
    y = (x - RMIN) % MODV;
    if (y < 0) y += MODV;
    return y + RMIN;
  endfunction

  task automatic model_add(input longint a, b, c, d, input bit conj);
    longint pr, pi;
    bit cr, ci;
    pr = conj ? (a * c + b * d) : (a * c - b * d);
    pi = conj ? (b * c - a * d) : (b * c + a * d);
    m_re = fit(m_re + pr, cr);
    m_im = fit(m_im + pi, ci);
    m_ovf = m_ovf | cr | ci;
  endtask

  task automatic model_clear();
    m_re = 0; m_im = 0; m_ovf = 1'b0;
  endtask

  // Offer one operand set, wait (bounded) for acceptance; returns at accept edge + 1.
  task automatic send(input logic signed [7:0] a, b, c, d, input bit conj, last);
    int t;
    t = 0;
    @(negedge clk);
    while (!op_ready && t < 50) begin @(negedge clk); t++; end
    if (!op_ready) check("op_ready_timeout", 0, 1);
    op_val = 1'b1; op_1_re = a; op_1_im = b; op_2_re = c; op_2_im = d;
    op_conj = conj; op_last = last;
    @(posedge clk); #1;
    op_val = 1'b0;
    op_1_re = 8'($urandom); op_1_im = 8'($urandom);
    op_2_re = 8'($urandom); op_2_im = 8'($urandom);
    op_conj = ~conj; op_last = ~last;
    model_add(a, b, c, d, conj);
  endtask

  // Cycles after the accept edge until res_val is seen (-1 on timeout).
  task automatic wait_res(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (res_val) begin lat = k; break; end
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("after_take_res_val", res_val, 0);
    check("after_take_op_ready", op_ready, 1);
    model_clear();
  endtask

  typedef struct {
    logic signed [7:0] a, b, c, d;
    bit conj;
    longint exp_re, exp_im;
  } vec_t;

  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    longint exp_im5;
    sw_rst = 1'b1; op_val = 1'b0; res_ready = 1'b0; op_conj = 1'b0; op_last = 1'b0;
    op_1_re = 8'sd0; op_1_im = 8'sd0; op_2_re = 8'sd0; op_2_im = 8'sd0;
    model_clear();

    vt[0] = '{8'sd2, 8'sd4, 8'sd3, 8'sd4, 1'b0, -10, 20};
    vt[1] = '{8'sd2, 8'sd4, 8'sd3, 8'sd4, 1'b1, 22, 4};
    vt[2] = '{-8'sd1, -8'sd1, 8'sd1, 8'sd1, 1'b0, 0, -2};
    vt[3] = '{8'sd127, 8'sd0, -8'sd128, 8'sd0, 1'b0, -16256, 0};
    vt[4] = '{8'sd5, -8'sd3, 8'sd2, 8'sd7, 1'b1, -11, -41};
    vt[5] = '{-8'sd128, 8'sd127, -8'sd128, -8'sd128, 1'b0, 32640, 128};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_val", res_val, 0);
    sw_rst = 1'b0;
    #1;
    check("rst_op_ready_after", op_ready, 1);
    check("rst_res_re", res_re, 0);
    check("rst_res_im", res_im, 0);
    check("rst_res_ovf", res_ovf, 0);

    // single-product vectors (tests 1, 2 and more)
    for (int i = 0; i < 6; i++) begin
      send(vt[i].a, vt[i].b, vt[i].c, vt[i].d, vt[i].conj, 1'b1);
      wait_res(lat);
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_re", i), res_re, vt[i].exp_re);
      check($sformatf("vec%0d_im", i), res_im, vt[i].exp_im);
      check($sformatf("vec%0d_ovf", i), res_ovf, 0);
      take_result();
    end

    // test 3: three-product accumulation
    seen = 1'b0;
    send(8'sd1, 8'sd1, 8'sd1, 8'sd1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; seen |= res_val; end
    send(8'sd2, 8'sd0, 8'sd3, 8'sd0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; seen |= res_val; end
    check("acc3_no_early_res", seen, 0);
    send(8'sd0, 8'sd1, 8'sd0, 8'sd1, 1'b0, 1'b1);
    wait_res(lat);
    check("acc3_latency", lat, 5);
    check("acc3_re", res_re, 5);
    check("acc3_im", res_im, 2);
    take_result();

    // test 4: consumer stall in RES
    send(8'sd2, 8'sd4, 8'sd3, 8'sd4, 1'b0, 1'b1);
    wait_res(lat);
    check("stall_latency", lat, 5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_res_val", res_val, 1);
      check("stall_res_re", res_re, -10);
      check("stall_res_im", res_im, 20);
      check("stall_op_ready", op_ready, 0);
    end
    take_result();

    // test 5: 32 worst-case products
    for (int k = 0; k < 32; k++)
      send(-8'sd128, -8'sd128, -8'sd128, -8'sd128, 1'b0, k == 31);
    wait_res(lat);
    exp_im5 = SAT ? 64'sd1048575 : -64'sd1048576;
    check("ovf_latency", lat, 5);
    check("ovf_re", res_re, 0);
    check("ovf_im", res_im, exp_im5);
    check("ovf_flag", res_ovf, SAT ? 1 : 0);
    check("ovf_model_im", res_im, m_im);
    take_result();
    check("ovf_cleared", res_ovf, 0);

    // test 6: reset in MUL with a partial accumulation
    send(8'sd1, 8'sd1, 8'sd1, 8'sd1, 1'b0, 1'b0);
    send(8'sd3, 8'sd3, 8'sd3, 8'sd3, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    sw_rst = 1'b1;
    #1;
    check("midrst_op_ready_low", op_ready, 0);
    @(posedge clk); #1;
    sw_rst = 1'b0;
    #1;
    model_clear();
    check("midrst_op_ready", op_ready, 1);
    check("midrst_res_val", res_val, 0);
    check("midrst_res_im", res_im, 0);
    send(8'sd2, 8'sd4, 8'sd3, 8'sd4, 1'b0, 1'b1);
    wait_res(lat);
    check("midrst_latency", lat, 5);
    check("midrst_re", res_re, -10);
    check("midrst_im", res_im, 20);
    take_result();

    // randomized groups against the reference model
    begin
      int grp;
      bit last;
      grp = 0;
      for (int n = 0; n < 60; n++) begin
        grp++;
        last = (n == 59) || (grp == 8) || ($urandom_range(0, 3) == 0);
        send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), last);
        if (last) begin
          grp = 0;
          wait_res(lat);
          check("rnd_latency", lat, 5);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          check("rnd_re", res_re, m_re);
          check("rnd_im", res_im, m_im);
          check("rnd_ovf", res_ovf, m_ovf);
          take_result();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
